// File: rtl/perf_result_collector.sv
// Collects total-cycle counter results into last/sum/count (and optional min/max) statistics
// behind a 32-bit read port with LO/HI shadowing. Optional feature macro: PERF_COLLECT_MINMAX_EN.
module perf_result_collector #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              perf_end,
  input  logic [63:0]       total_cycle,
  input  logic              clr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              sample_pending
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  localparam logic [ADDR_W-1:0] AddrLastLo = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] AddrLastHi = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrSumLo  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] AddrSumHi  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] AddrMinLo  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] AddrMinHi  = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] AddrMaxLo  = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] AddrMaxHi  = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] AddrCount  = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] AddrStatus = ADDR_W'(9);

  logic             end_q, end_d;
  logic [63:0]      last_q, last_d;
  logic [63:0]      sum_q, sum_d;
  logic             sum_ovf_q, sum_ovf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q;
  logic [64:0]      sum_ext;
  logic [63:0]      min_val, max_val;

`ifdef PERF_COLLECT_MINMAX_EN
  logic [63:0] min_q, min_d;
  logic [63:0] max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (clr) begin
      min_d = '1;
      max_d = '0;
    end else if (end_q) begin
      if (total_cycle < min_q) min_d = total_cycle;
      if (total_cycle > max_q) max_d = total_cycle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_val = min_q;
  assign max_val = max_q;
`else
  assign min_val = '0;
  assign max_val = '0;
`endif

  assign sum_ext = {1'b0, sum_q} + {1'b0, total_cycle};

  // Statistics update; clr takes priority and discards a sample landing in the same cycle.
  always_comb begin
    end_d     = perf_end;
    last_d    = last_q;
    sum_d     = sum_q;
    sum_ovf_d = sum_ovf_q;
    count_d   = count_q;
    if (clr) begin
      end_d     = 1'b0;
      last_d    = '0;
      sum_d     = '0;
      sum_ovf_d = 1'b0;
      count_d   = '0;
    end else if (end_q) begin
      last_d = total_cycle;
      if (sum_ext[64]) begin
        sum_d     = '1;
        sum_ovf_d = 1'b1;
      end else begin
        sum_d = sum_ext[63:0];
      end
      if (count_q != CntMax) count_d = count_q + 1'b1;
    end
  end

  // Read mux on pre-update state; LO reads latch the matching upper word into the shadow.
  always_comb begin
    rd_data_d = rd_data_q;
    shadow_d  = shadow_q;
    if (rd_en) begin
      case (rd_addr)
        AddrLastLo: begin
          rd_data_d = last_q[31:0];
          shadow_d  = last_q[63:32];
        end
        AddrSumLo: begin
          rd_data_d = sum_q[31:0];
          shadow_d  = sum_q[63:32];
        end
        AddrMinLo: begin
          rd_data_d = min_val[31:0];
          shadow_d  = min_val[63:32];
        end
        AddrMaxLo: begin
          rd_data_d = max_val[31:0];
          shadow_d  = max_val[63:32];
        end
        AddrLastHi, AddrSumHi, AddrMinHi, AddrMaxHi: rd_data_d = shadow_q;
        AddrCount:  rd_data_d = 32'(count_q);
        AddrStatus: rd_data_d = {30'b0, end_q, sum_ovf_q};
        default:    rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      end_q      <= 1'b0;
      last_q     <= '0;
      sum_q      <= '0;
      sum_ovf_q  <= 1'b0;
      count_q    <= '0;
      shadow_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      end_q      <= end_d;
      last_q     <= last_d;
      sum_q      <= sum_d;
      sum_ovf_q  <= sum_ovf_d;
      count_q    <= count_d;
      shadow_q   <= shadow_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
    end
  end

  assign rd_data        = rd_data_q;
  assign rd_valid       = rd_valid_q;
  assign sample_pending = end_q;

endmodule
